keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_debounce.sv | 54 +++++
 rtl/keypad_scan.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-map constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        HOLD,
        WAIT_REL
    } emit_state_t;

    typedef enum logic [1:0] {
        CODE_NONE,
        CODE_KEY,
        CODE_MULTI
    } code_kind_t;

    // idx is row*4+col; forced to zero for NONE and MULTI so frames compare cleanly
    typedef struct packed {
        code_kind_t kind;
        logic [3:0] idx;
    } frame_code_t;

    localparam int          CODE_W     = $bits(frame_code_t);
    localparam frame_code_t FRAME_NONE = '{kind: CODE_NONE, idx: 4'd0};

    localparam logic [3:0] IDX_ADD  = 4'd3;
    localparam logic [3:0] IDX_SUB  = 4'd7;
    localparam logic [3:0] IDX_MUL  = 4'd11;
    localparam logic [3:0] IDX_DIV  = 4'd15;
    localparam logic [3:0] IDX_STAR = 4'd12;
    localparam logic [3:0] IDX_HASH = 4'd14;

    function automatic logic [9:0] digit_onehot(input logic [3:0] idx);
        logic [9:0] oh;
        oh = '0;
        case (idx)
            4'd0:    oh[1] = 1'b1;
            4'd1:    oh[2] = 1'b1;
            4'd2:    oh[3] = 1'b1;
            4'd4:    oh[4] = 1'b1;
            4'd5:    oh[5] = 1'b1;
            4'd6:    oh[6] = 1'b1;
            4'd8:    oh[7] = 1'b1;
            4'd9:    oh[8] = 1'b1;
            4'd10:   oh[9] = 1'b1;
            4'd13:   oh[0] = 1'b1;
            default: oh    = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-code debouncer: a code becomes stable after DEBOUNCE_N identical consecutive frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_vld,
    input  logic [CODE_W-1:0] frame_in,
    output logic [CODE_W-1:0] stable_code,
    output logic              stable_upd
);

    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              same;
    logic              reach;

    always_comb begin
        same = (frame_in == cand);
        if (!same)
            cnt_next = CNT_W'(1);
        else if (cnt == CNT_W'(DEBOUNCE_N))
            cnt_next = cnt;
        else
            cnt_next = cnt + 1'b1;
        // fire once on the frame that completes the run, not on every later repeat
        reach = (cnt_next == CNT_W'(DEBOUNCE_N)) && !(same && cnt == CNT_W'(DEBOUNCE_N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= FRAME_NONE;
            cnt         <= '0;
            stable_code <= FRAME_NONE;
            stable_upd  <= 1'b0;
        end else begin
            stable_upd <= 1'b0;
            if (frame_vld) begin
                cand <= frame_in;
                cnt  <= cnt_next;
                if (reach) begin
                    stable_code <= frame_in;
                    stable_upd  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with debounced single-shot key emission.
// Define KEYPAD_CODE_EN to add the raw key_code/key_vld outputs.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 4,
    parameter int SET_LEN    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [9:0] KEY,
    output logic       Add,
    output logic       Sub,
    output logic       Mul,
    output logic       Div,
    output logic       set,
    output logic       clr
`ifdef KEYPAD_CODE_EN
    ,
    output logic [3:0] key_code,
    output logic       key_vld
`endif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SET_W = $clog2(SET_LEN + 1);

    // rows idle high, so the synchroniser clears to the released level
    logic [3:0] row_meta, row_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    logic [DIV_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic             dwell_end;

    assign dwell_end = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
    assign col       = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
        end else if (dwell_end) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    logic              acc_found, acc_multi;
    logic [3:0]        acc_idx;
    logic [2:0]        hit_cnt;
    logic [1:0]        hit_row;
    logic              sum_found, sum_multi;
    logic [3:0]        sum_idx;
    frame_code_t       frame_code;
    logic              frame_vld;
    logic [CODE_W-1:0] frame_q;

    always_comb begin
        hit_cnt = '0;
        hit_row = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (hit_cnt == 3'd0)
                    hit_row = 2'(r);
                hit_cnt = hit_cnt + 3'd1;
            end
        end
        sum_found = acc_found | (hit_cnt != 3'd0);
        sum_multi = acc_multi | (hit_cnt > 3'd1) | (acc_found & (hit_cnt != 3'd0));
        sum_idx   = acc_found ? acc_idx : {hit_row, col_idx};
        frame_code = FRAME_NONE;
        if (sum_multi)
            frame_code = '{kind: CODE_MULTI, idx: 4'd0};
        else if (sum_found)
            frame_code = '{kind: CODE_KEY, idx: sum_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_found <= 1'b0;
            acc_multi <= 1'b0;
            acc_idx   <= '0;
            frame_vld <= 1'b0;
            frame_q   <= FRAME_NONE;
        end else begin
            frame_vld <= 1'b0;
            if (dwell_end) begin
                if (col_idx == 2'd3) begin
                    frame_vld <= 1'b1;
                    frame_q   <= frame_code;
                    acc_found <= 1'b0;
                    acc_multi <= 1'b0;
                    acc_idx   <= '0;
                end else begin
                    acc_found <= sum_found;
                    acc_multi <= sum_multi;
                    acc_idx   <= sum_idx;
                end
            end
        end
    end

    logic [CODE_W-1:0] stable_bits;
    logic              stable_upd;
    frame_code_t       stable;

    keypad_debounce #(
        .DEBOUNCE_N(DEBOUNCE_N)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_vld  (frame_vld),
        .frame_in   (frame_q),
        .stable_code(stable_bits),
        .stable_upd (stable_upd)
    );

    assign stable = frame_code_t'(stable_bits);

    emit_state_t      state, state_next;
    logic [3:0]       key_idx;
    logic [SET_W-1:0] set_cnt;
    logic             none_seen;
    logic             hold_out;

    // none_seen needs an observed stable NONE; the reset value of the stable
    // code does not count, so a key held through reset is never emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_idx   <= '0;
            set_cnt   <= '0;
            none_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (stable_upd)
                none_seen <= (stable.kind == CODE_NONE);
            if (state == IDLE && state_next == LOAD)
                key_idx <= stable.idx;
            if (state == STROBE)
                set_cnt <= set_cnt + 1'b1;
            else
                set_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        hold_out   = 1'b0;
        set        = 1'b0;
        clr        = 1'b0;
        KEY        = '0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Mul        = 1'b0;
        Div        = 1'b0;
        case (state)
            IDLE: begin
                if (stable_upd && stable.kind == CODE_KEY && none_seen)
                    state_next = LOAD;
                else if (stable_upd && stable.kind != CODE_NONE)
                    state_next = WAIT_REL;
            end
            LOAD: begin
                hold_out = 1'b1;
                if (key_idx == IDX_STAR) begin
                    clr        = 1'b1;
                    state_next = WAIT_REL;
                end else begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                hold_out = 1'b1;
                set      = 1'b1;
                if (set_cnt == SET_W'(SET_LEN - 1))
                    state_next = HOLD;
            end
            HOLD: begin
                hold_out   = 1'b1;
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (stable.kind == CODE_NONE)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (hold_out) begin
            KEY = digit_onehot(key_idx);
            Add = (key_idx == IDX_ADD);
            Sub = (key_idx == IDX_SUB);
            Mul = (key_idx == IDX_MUL);
            Div = (key_idx == IDX_DIV);
        end
    end

`ifdef KEYPAD_CODE_EN
    assign key_code = key_idx;
    assign key_vld  = (state == LOAD);
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a behavioural 4x4 keypad matrix.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row, col;
    logic [9:0] KEY;
    logic       Add, Sub, Mul, Div, set, clr;
`ifdef KEYPAD_CODE_EN
    logic [3:0] key_code;
    logic       key_vld;
`endif

    logic [15:0] pressed = '0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV  (4),
        .DEBOUNCE_N(2),
        .SET_LEN   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row     (row),
        .col     (col),
        .KEY     (KEY),
        .Add     (Add),
        .Sub     (Sub),
        .Mul     (Mul),
        .Div     (Div),
        .set     (set),
        .clr     (clr)
`ifdef KEYPAD_CODE_EN
        ,
        .key_code(key_code),
        .key_vld (key_vld)
`endif
    );

    // a pressed key shorts its row to its column when that column is driven low
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    int   set_rises  = 0;
    int   clr_cycles = 0;
    int   key_cycles = 0;
    int   excl_viol  = 0;
    logic set_d      = 1'b0;

    always @(negedge clk) begin
        int n;
        if (set && !set_d)
            set_rises++;
        set_d = set;
        if (clr)
            clr_cycles++;
        if (KEY != 10'd0)
            key_cycles++;
        n = int'(KEY != 10'd0) + int'(Add) + int'(Sub) + int'(Mul) + int'(Div);
        if (n > 1 || $countones(KEY) > 1)
            excl_viol++;
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [9:0] prev_key;
    logic [3:0] prev_ops;
    logic       prev_set;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        prev_key = KEY;
        prev_ops = {Add, Sub, Mul, Div};
        prev_set = set;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_set(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (set)
                ok = 1'b1;
        end
    endtask

    // LOAD one cycle before set, 3 set cycles, HOLD with set low, then cleared
    task automatic check_emit(input string tag, input logic [9:0] key_exp, input logic [3:0] ops_exp);
        logic ok;
        wait_set(ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_load_key"}, 32'(prev_key), 32'(key_exp));
            check({tag, "_load_ops"}, 32'(prev_ops), 32'(ops_exp));
            check({tag, "_load_set"}, 32'(prev_set), 32'd0);
            for (int i = 0; i < 3; i++) begin
                check({tag, "_strobe_set"}, 32'(set), 32'd1);
                check({tag, "_strobe_key"}, 32'(KEY), 32'(key_exp));
                check({tag, "_strobe_ops"}, 32'({Add, Sub, Mul, Div}), 32'(ops_exp));
                tick();
            end
            check({tag, "_hold_set"}, 32'(set), 32'd0);
            check({tag, "_hold_key"}, 32'(KEY), 32'(key_exp));
            check({tag, "_hold_ops"}, 32'({Add, Sub, Mul, Div}), 32'(ops_exp));
            tick();
            check({tag, "_after_key"}, 32'(KEY), 32'd0);
            check({tag, "_after_ops"}, 32'({Add, Sub, Mul, Div}), 32'd0);
        end
    endtask

    initial begin
        int   s0, c0, k0;
        logic ok;

        rst_n = 1'b0;
        #1;
        check("rst_col", 32'(col), 32'hE);
        check("rst_key", 32'(KEY), 32'd0);
        check("rst_ops", 32'({Add, Sub, Mul, Div}), 32'd0);
        check("rst_set", 32'(set), 32'd0);
        check("rst_clr", 32'(clr), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(48);

        // '5' held for 10 frames: exactly one emission
        s0 = set_rises;
        pressed = 16'h0020;
        check_emit("k5", 10'b0000100000, 4'b0000);
        run(120);
        check("k5_single", 32'(set_rises - s0), 32'd1);
        pressed = '0;
        run(64);

        pressed = 16'h0008;
        check_emit("kA", 10'd0, 4'b1000);
        pressed = '0;
        run(64);

        pressed = 16'h4000;
        check_emit("khash", 10'd0, 4'b0000);
        pressed = '0;
        run(64);

        // '7' bouncing every frame never becomes stable
        s0 = set_rises;
        c0 = clr_cycles;
        k0 = key_cycles;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0100 : 16'h0000;
            run(16);
        end
        run(64);
        check("bounce_set", 32'(set_rises - s0), 32'd0);
        check("bounce_clr", 32'(clr_cycles - c0), 32'd0);
        check("bounce_key", 32'(key_cycles - k0), 32'd0);

        // '1'+'2' together, then '1' alone: nothing until a full release
        s0 = set_rises;
        k0 = key_cycles;
        pressed = 16'h0003;
        run(64);
        pressed = 16'h0001;
        run(64);
        check("multi_set", 32'(set_rises - s0), 32'd0);
        check("multi_key", 32'(key_cycles - k0), 32'd0);
        pressed = '0;
        run(64);
        pressed = 16'h0001;
        check_emit("k1", 10'b0000000010, 4'b0000);
        run(32);
        check("k1_single", 32'(set_rises - s0), 32'd1);
        pressed = '0;
        run(64);

        // reset in the 2nd STROBE cycle
        pressed = 16'h0020;
        wait_set(ok);
        check("rststrobe_seen", 32'(ok), 32'd1);
        tick();
        check("rststrobe_set_before", 32'(set), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rststrobe_set", 32'(set), 32'd0);
        check("rststrobe_key", 32'(KEY), 32'd0);
        check("rststrobe_ops", 32'({Add, Sub, Mul, Div}), 32'd0);
        check("rststrobe_col", 32'(col), 32'hE);
        run(2);
        rst_n = 1'b1;
        s0 = set_rises;
        run(96);
        check("rst_held_noemit", 32'(set_rises - s0), 32'd0);
        pressed = '0;
        run(64);
        check("rst_release_noemit", 32'(set_rises - s0), 32'd0);
        pressed = 16'h0020;
        check_emit("k5_after_rst", 10'b0000100000, 4'b0000);
        pressed = '0;
        run(64);

        // '*' gives one clr cycle and no set
        s0 = set_rises;
        c0 = clr_cycles;
        pressed = 16'h1000;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (clr)
                ok = 1'b1;
        end
        check("star_seen", 32'(ok), 32'd1);
        check("star_key", 32'(KEY), 32'd0);
        check("star_set", 32'(set), 32'd0);
`ifdef KEYPAD_CODE_EN
        check("star_code", 32'(key_code), 32'd12);
        check("star_vld", 32'(key_vld), 32'd1);
`endif
        tick();
        check("star_clr_fall", 32'(clr), 32'd0);
`ifdef KEYPAD_CODE_EN
        check("star_vld_fall", 32'(key_vld), 32'd0);
`endif
        run(64);
        pressed = '0;
        run(64);
        check("star_no_set", 32'(set_rises - s0), 32'd0);
        check("star_clr_once", 32'(clr_cycles - c0), 32'd1);

        check("exclusive_outputs", 32'(excl_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
